cpu_datapath: RTL and testbench

Single-bus 32-bit CPU datapath: register file, special registers (PC, IR, MAR, MDR, Y, Z, HI, LO), ALU, 512-word RAM, select/encode logic, branch-condition flip-flop and I/O ports. All transfers use one shared 32-bit bus. The block is driven cycle-by-cycle by an external control unit or bench, which sequences the control strobes.

---
 rtl/cpu_datapath.sv | 198 +++++++++++++++++++
 tb/tb_cpu_datapath.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: register file, special registers, ALU,
// 512x32 RAM, select/encode logic, branch-condition flip-flop and I/O ports.
module cpu_datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic        PCout,
  input  logic        MDRout,
  input  logic        RZoutHi,
  input  logic        RZoutLo,
  input  logic        RYout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        IRout,
  input  logic        MARout,
  input  logic        InPortOut,
  input  logic        RCout,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        RYin,
  input  logic        RZinHi,
  input  logic        RZinLo,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        OutPortIn,
  input  logic        InPortIn,
  input  logic        CONin,
  input  logic        Rin,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R6in,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        IncPC,
  input  logic        MDRread,
  input  logic        RAMwrite,
  input  logic [31:0] InPortData,
  output logic [31:0] OutPortData,
  output logic        CON,
  output logic [31:0] BusMuxOut
);

  logic [31:0] regs_r [16];
  logic [31:0] pc_r, ir_r, mdr_r, y_r, zhi_r, zlo_r, hi_r, lo_r;
  logic [31:0] inport_r, outport_r;
  logic [8:0]  mar_r;
  logic        con_r;
  // RAM is not reset; it starts at zero when the simulation or bitstream loads
  logic [31:0] ram_r [512] = '{default: 32'h0000_0000};

  logic [3:0]         sel_s;
  logic               sel_en_s;
  logic [31:0]        bus_s;
  logic [15:0]        reg_wr_s;
  logic [63:0]        alu_res_s;
  logic signed [63:0] mul_s;
  logic signed [31:0] div_q_s, div_r_s;
  logic               cond_s;
  logic [31:0]        mdr_in_s;

  // Register-select encoder: picks the IR field named by Gra/Grb/Grc
  always_comb begin
    sel_s    = 4'h0;
    sel_en_s = 1'b0;
    if (Gra) begin
      sel_s    = ir_r[26:23];
      sel_en_s = 1'b1;
    end else if (Grb) begin
      sel_s    = ir_r[22:19];
      sel_en_s = 1'b1;
    end else if (Grc) begin
      sel_s    = ir_r[18:15];
      sel_en_s = 1'b1;
    end else begin
      sel_s    = 4'h0;
      sel_en_s = 1'b0;
    end
  end

  // Bus source mux in fixed priority order; idle bus reads zero
  always_comb begin
    bus_s = 32'h0000_0000;
    if (PCout)           bus_s = pc_r;
    else if (MDRout)     bus_s = mdr_r;
    else if (RZoutHi)    bus_s = zhi_r;
    else if (RZoutLo)    bus_s = zlo_r;
    else if (RYout)      bus_s = y_r;
    else if (HIout)      bus_s = hi_r;
    else if (LOout)      bus_s = lo_r;
    else if (IRout)      bus_s = ir_r;
    else if (MARout)     bus_s = {23'h000000, mar_r};
    else if (InPortOut)  bus_s = inport_r;
    else if (RCout)      bus_s = {{13{ir_r[18]}}, ir_r[18:0]};
    else if (Rout && sel_en_s)
      bus_s = regs_r[sel_s];
    else if (BAout && sel_en_s)
      bus_s = (sel_s == 4'h0) ? 32'h0000_0000 : regs_r[sel_s];
    else
      bus_s = 32'h0000_0000;
  end

  assign BusMuxOut   = bus_s;
  assign OutPortData = outport_r;
  assign CON         = con_r;
  assign mdr_in_s    = MDRread ? ram_r[mar_r] : bus_s;

  // Register-file write decode: selected register plus the direct loads
  always_comb begin
    reg_wr_s    = (Rin && sel_en_s) ? (16'h0001 << sel_s) : 16'h0000;
    reg_wr_s[1] = reg_wr_s[1] | R1in;
    reg_wr_s[2] = reg_wr_s[2] | R2in;
    reg_wr_s[6] = reg_wr_s[6] | R6in;
  end

  // ALU: A is Y, B is the bus; operation taken from the IR opcode
  always_comb begin
    alu_res_s = 64'h0;
    div_q_s   = 32'sh0;
    div_r_s   = 32'sh0;
    mul_s     = $signed({{32{y_r[31]}}, y_r}) * $signed({{32{bus_s[31]}}, bus_s});
    case (ir_r[31:27])
      5'b00100: alu_res_s = {32'h0, y_r - bus_s};
      5'b00101: alu_res_s = {32'h0, y_r & bus_s};
      5'b00110: alu_res_s = {32'h0, y_r | bus_s};
      5'b00111: alu_res_s = {32'h0, y_r >> bus_s[4:0]};
      5'b01001: alu_res_s = {32'h0, y_r << bus_s[4:0]};
      5'b01111: begin
        if (bus_s == 32'h0) begin
          alu_res_s = {y_r, 32'hFFFF_FFFF};
        end else begin
          div_q_s   = $signed(y_r) / $signed(bus_s);
          div_r_s   = $signed(y_r) % $signed(bus_s);
          alu_res_s = {div_r_s, div_q_s};
        end
      end
      5'b10000: alu_res_s = mul_s;
      5'b10001: alu_res_s = {32'h0, 32'h0 - bus_s};
      5'b10010: alu_res_s = {32'h0, ~bus_s};
      default:  alu_res_s = {32'h0, y_r + bus_s};
    endcase
  end

  // Branch condition evaluated on the bus, chosen by the C2 field
  always_comb begin
    cond_s = 1'b0;
    case (ir_r[20:19])
      2'b00:   cond_s = (bus_s == 32'h0);
      2'b01:   cond_s = (bus_s != 32'h0);
      2'b10:   cond_s = ~bus_s[31];
      2'b11:   cond_s = bus_s[31];
      default: cond_s = 1'b0;
    endcase
  end

  // Special registers, I/O ports and CON; reset beats every load
  always_ff @(posedge clock) begin
    if (!clear) begin
      pc_r <= 32'h0; ir_r <= 32'h0; mar_r <= 9'h0; mdr_r <= 32'h0;
      y_r <= 32'h0; zhi_r <= 32'h0; zlo_r <= 32'h0; hi_r <= 32'h0;
      lo_r <= 32'h0; inport_r <= 32'h0; outport_r <= 32'h0; con_r <= 1'b0;
    end else begin
      if (IncPC)          pc_r <= pc_r + 32'h1;
      else if (PCin)      pc_r <= bus_s;
      if (IRin)           ir_r <= bus_s;
      if (MARin)          mar_r <= bus_s[8:0];
      if (MDRin)          mdr_r <= mdr_in_s;
      if (RYin)           y_r <= bus_s;
      if (RZinHi)         zhi_r <= alu_res_s[63:32];
      if (RZinLo)         zlo_r <= alu_res_s[31:0];
      if (HIin)           hi_r <= bus_s;
      if (LOin)           lo_r <= bus_s;
      if (InPortIn)       inport_r <= InPortData;
      if (OutPortIn)      outport_r <= bus_s;
      if (CONin)          con_r <= cond_s;
    end
  end

  // General-purpose register file R0-R15
  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) regs_r[i] <= 32'h0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (reg_wr_s[i]) regs_r[i] <= bus_s;
      end
    end
  end

  // RAM write port; a reset cycle blocks the write
  always_ff @(posedge clock) begin
    if (clear && RAMwrite) ram_r[mar_r] <= mdr_r;
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed, table-driven bench for cpu_datapath: each record is one clock
// cycle of strobes with optional expected bus / OutPort / CON values.
module tb_cpu_datapath;

  logic clock = 1'b0;
  logic clear;
  logic PCout, MDRout, RZoutHi, RZoutLo, RYout, HIout, LOout, IRout, MARout;
  logic InPortOut, RCout, Rout, BAout, PCin, IRin, MARin, MDRin, RYin;
  logic RZinHi, RZinLo, HIin, LOin, OutPortIn, InPortIn, CONin, Rin;
  logic R1in, R2in, R6in, Gra, Grb, Grc, IncPC, MDRread, RAMwrite;
  logic [31:0] InPortData, OutPortData, BusMuxOut;
  logic        CON;

  always #5 clock = ~clock;

  cpu_datapath dut (
    .clock(clock), .clear(clear), .PCout(PCout), .MDRout(MDRout),
    .RZoutHi(RZoutHi), .RZoutLo(RZoutLo), .RYout(RYout), .HIout(HIout),
    .LOout(LOout), .IRout(IRout), .MARout(MARout), .InPortOut(InPortOut),
    .RCout(RCout), .Rout(Rout), .BAout(BAout), .PCin(PCin), .IRin(IRin),
    .MARin(MARin), .MDRin(MDRin), .RYin(RYin), .RZinHi(RZinHi),
    .RZinLo(RZinLo), .HIin(HIin), .LOin(LOin), .OutPortIn(OutPortIn),
    .InPortIn(InPortIn), .CONin(CONin), .Rin(Rin), .R1in(R1in), .R2in(R2in),
    .R6in(R6in), .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC),
    .MDRread(MDRread), .RAMwrite(RAMwrite), .InPortData(InPortData),
    .OutPortData(OutPortData), .CON(CON), .BusMuxOut(BusMuxOut)
  );

  localparam logic [35:0] PCO = 36'd1 << 0,  MDRO = 36'd1 << 1,  ZHO = 36'd1 << 2;
  localparam logic [35:0] ZLO = 36'd1 << 3,  YO = 36'd1 << 4,    HIO = 36'd1 << 5;
  localparam logic [35:0] LOO = 36'd1 << 6,  IRO = 36'd1 << 7,   MARO = 36'd1 << 8;
  localparam logic [35:0] INO = 36'd1 << 9,  RCO = 36'd1 << 10,  RO = 36'd1 << 11;
  localparam logic [35:0] BAO = 36'd1 << 12, PCI = 36'd1 << 13,  IRI = 36'd1 << 14;
  localparam logic [35:0] MARI = 36'd1 << 15, MDRI = 36'd1 << 16, YI = 36'd1 << 17;
  localparam logic [35:0] ZHI = 36'd1 << 18, ZLI = 36'd1 << 19,  HII = 36'd1 << 20;
  localparam logic [35:0] LOI = 36'd1 << 21, OUTI = 36'd1 << 22, INI = 36'd1 << 23;
  localparam logic [35:0] CONI = 36'd1 << 24, RI = 36'd1 << 25,  R1I = 36'd1 << 26;
  localparam logic [35:0] R2I = 36'd1 << 27, R6I = 36'd1 << 28,  GRA = 36'd1 << 29;
  localparam logic [35:0] GRB = 36'd1 << 30, GRC = 36'd1 << 31,  INC = 36'd1 << 32;
  localparam logic [35:0] MRD = 36'd1 << 33, RAMW = 36'd1 << 34, RST = 36'd1 << 35;

  typedef struct {
    string       name;
    logic [35:0] ctl;
    logic [31:0] din;
    bit          cb;  logic [31:0] eb;
    bit          co;  logic [31:0] eo;
    bit          cc;  logic        ec;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];

  function automatic vec_t mk(string n, logic [35:0] c, logic [31:0] d = 32'h0,
                              bit cb = 1'b0, logic [31:0] eb = 32'h0,
                              bit co = 1'b0, logic [31:0] eo = 32'h0,
                              bit cc = 1'b0, logic ec = 1'b0);
    vec_t v;
    v.name = n; v.ctl = c; v.din = d; v.cb = cb; v.eb = eb;
    v.co = co; v.eo = eo; v.cc = cc; v.ec = ec;
    return v;
  endfunction

  function automatic logic has(logic [35:0] c, logic [35:0] m);
    return (c & m) != 36'h0;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step(vec_t v);
    clear = ~has(v.ctl, RST);
    PCout = has(v.ctl, PCO);   MDRout = has(v.ctl, MDRO); RZoutHi = has(v.ctl, ZHO);
    RZoutLo = has(v.ctl, ZLO); RYout = has(v.ctl, YO);    HIout = has(v.ctl, HIO);
    LOout = has(v.ctl, LOO);   IRout = has(v.ctl, IRO);   MARout = has(v.ctl, MARO);
    InPortOut = has(v.ctl, INO); RCout = has(v.ctl, RCO); Rout = has(v.ctl, RO);
    BAout = has(v.ctl, BAO);   PCin = has(v.ctl, PCI);    IRin = has(v.ctl, IRI);
    MARin = has(v.ctl, MARI);  MDRin = has(v.ctl, MDRI);  RYin = has(v.ctl, YI);
    RZinHi = has(v.ctl, ZHI);  RZinLo = has(v.ctl, ZLI);  HIin = has(v.ctl, HII);
    LOin = has(v.ctl, LOI);    OutPortIn = has(v.ctl, OUTI); InPortIn = has(v.ctl, INI);
    CONin = has(v.ctl, CONI);  Rin = has(v.ctl, RI);      R1in = has(v.ctl, R1I);
    R2in = has(v.ctl, R2I);    R6in = has(v.ctl, R6I);    Gra = has(v.ctl, GRA);
    Grb = has(v.ctl, GRB);     Grc = has(v.ctl, GRC);     IncPC = has(v.ctl, INC);
    MDRread = has(v.ctl, MRD); RAMwrite = has(v.ctl, RAMW);
    InPortData = v.din;
    @(negedge clock);
    if (v.cb) chk({v.name, "/bus"}, BusMuxOut, v.eb);
    @(posedge clock);
    #1;
    if (v.co) chk({v.name, "/out"}, OutPortData, v.eo);
    if (v.cc) chk({v.name, "/con"}, {31'h0, CON}, {31'h0, v.ec});
  endtask

  initial begin
    vec_t v;
    logic [35:0] rc;

    // Preload every register with a nonzero value, then reset with random strobes
    step(mk("init", RST));
    step(mk("ld_in", INI, 32'h1234_5678));
    step(mk("ld_all", INO | MDRI | YI | PCI | HII | LOI | OUTI | MARI | IRI | GRA | RI |
                      R1I | ZLI | ZHI, 32'h0, 1'b1, 32'h1234_5678));
    step(mk("ram_wr", RAMW));
    step(mk("ld_in2", INI, 32'h0BAD_F00D));
    step(mk("mdr2", INO | MDRI));
    step(mk("con_set", CONI, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b1, 1'b1));
    for (int k = 0; k < 2; k++) begin
      rc = 36'({$urandom(), $urandom()}) | RST | RAMW;
      step(mk("rst_rand", rc, $urandom()));
    end
    step(mk("rst_pc", PCO, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0));
    step(mk("rst_mdr", MDRO, 32'h0, 1'b1, 32'h0));
    step(mk("rst_zhi", ZHO, 32'h0, 1'b1, 32'h0));
    step(mk("rst_zlo", ZLO, 32'h0, 1'b1, 32'h0));
    step(mk("rst_y", YO, 32'h0, 1'b1, 32'h0));
    step(mk("rst_hi", HIO, 32'h0, 1'b1, 32'h0));
    step(mk("rst_lo", LOO, 32'h0, 1'b1, 32'h0));
    step(mk("rst_ir", IRO, 32'h0, 1'b1, 32'h0));
    step(mk("rst_mar", MARO, 32'h0, 1'b1, 32'h0));
    step(mk("rst_inport", INO, 32'h0, 1'b1, 32'h0));
    step(mk("rst_r0", GRA | RO, 32'h0, 1'b1, 32'h0));
    step(mk("ram_keep_a", INI, 32'h0000_0078));
    step(mk("ram_keep_b", INO | MARI));
    step(mk("ram_keep_c", MRD | MDRI));
    step(mk("ram_keep", MDRO, 32'h0, 1'b1, 32'h1234_5678));

    // I/O path and instruction fetch
    tbl.push_back(mk("in2a", INI, 32'h0000_002A));
    tbl.push_back(mk("r6_load", INO | R6I, 32'h0, 1'b1, 32'h0000_002A));
    tbl.push_back(mk("in_instr", INI, 32'hB300_0000));
    tbl.push_back(mk("mdr_instr", INO | MDRI));
    tbl.push_back(mk("bus_idle", MARI, 32'h0, 1'b1, 32'h0));
    tbl.push_back(mk("ram0_wr", RAMW));
    tbl.push_back(mk("mdr_clr", MDRI));
    tbl.push_back(mk("fetch1", PCO | MARI, 32'h0, 1'b1, 32'h0));
    tbl.push_back(mk("fetch2", MRD | MDRI | INC));
    tbl.push_back(mk("fetch3", MDRO | IRI, 32'h0, 1'b1, 32'hB300_0000));
    tbl.push_back(mk("ir_read", IRO, 32'h0, 1'b1, 32'hB300_0000));
    tbl.push_back(mk("pc_inc", PCO, 32'h0, 1'b1, 32'h0000_0001));
    tbl.push_back(mk("outport", GRA | RO | OUTI, 32'h0, 1'b1, 32'h2A, 1'b1, 32'h2A));
    // ALU add (IR opcode 10110 falls through to add)
    tbl.push_back(mk("add_y_in", INI, 32'd5));
    tbl.push_back(mk("add_y", INO | YI));
    tbl.push_back(mk("add_y_rd", YO, 32'h0, 1'b1, 32'd5));
    tbl.push_back(mk("add_b_in", INI, 32'd7));
    tbl.push_back(mk("add_z", INO | ZLI | ZHI));
    tbl.push_back(mk("add_lo", ZLO, 32'h0, 1'b1, 32'd12));
    tbl.push_back(mk("add_hi", ZHO, 32'h0, 1'b1, 32'd0));
    // ALU mul
    tbl.push_back(mk("mul_ir_in", INI, 32'h8000_0000));
    tbl.push_back(mk("mul_ir", INO | IRI));
    tbl.push_back(mk("mul_y_in", INI, 32'hFFFF_FFFE));
    tbl.push_back(mk("mul_y", INO | YI));
    tbl.push_back(mk("mul_b_in", INI, 32'd3));
    tbl.push_back(mk("mul_z", INO | ZLI | ZHI));
    tbl.push_back(mk("mul_lo", ZLO, 32'h0, 1'b1, 32'hFFFF_FFFA));
    tbl.push_back(mk("mul_hi", ZHO, 32'h0, 1'b1, 32'hFFFF_FFFF));
    // ALU div and divide-by-zero
    tbl.push_back(mk("div_ir_in", INI, 32'h7800_0000));
    tbl.push_back(mk("div_ir", INO | IRI));
    tbl.push_back(mk("div_y_in", INI, 32'd17));
    tbl.push_back(mk("div_y", INO | YI));
    tbl.push_back(mk("div_b_in", INI, 32'd5));
    tbl.push_back(mk("div_z", INO | ZLI | ZHI));
    tbl.push_back(mk("div_lo", ZLO, 32'h0, 1'b1, 32'd3));
    tbl.push_back(mk("div_hi", ZHO, 32'h0, 1'b1, 32'd2));
    tbl.push_back(mk("div0_z", ZLI | ZHI));
    tbl.push_back(mk("div0_lo", ZLO, 32'h0, 1'b1, 32'hFFFF_FFFF));
    tbl.push_back(mk("div0_hi", ZHO, 32'h0, 1'b1, 32'd17));
    // ALU sub and neg
    tbl.push_back(mk("sub_ir_in", INI, 32'h2000_0000));
    tbl.push_back(mk("sub_ir", INO | IRI));
    tbl.push_back(mk("sub_b_in", INI, 32'd20));
    tbl.push_back(mk("sub_z", INO | ZLI | ZHI));
    tbl.push_back(mk("sub_lo", ZLO, 32'h0, 1'b1, 32'hFFFF_FFFD));
    tbl.push_back(mk("sub_hi", ZHO, 32'h0, 1'b1, 32'h0));
    tbl.push_back(mk("neg_ir_in", INI, 32'h8800_0000));
    tbl.push_back(mk("neg_ir", INO | IRI));
    tbl.push_back(mk("neg_b_in", INI, 32'd5));
    tbl.push_back(mk("neg_z", INO | ZLI));
    tbl.push_back(mk("neg_lo", ZLO, 32'h0, 1'b1, 32'hFFFF_FFFB));
    // Memory at the top address; MAR keeps only bus[8:0]
    tbl.push_back(mk("mar_in", INI, 32'hFFFF_FFFF));
    tbl.push_back(mk("mar_ld", INO | MARI));
    tbl.push_back(mk("mar_rd", MARO, 32'h0, 1'b1, 32'h0000_01FF));
    tbl.push_back(mk("mdr_in", INI, 32'hDEAD_BEEF));
    tbl.push_back(mk("mdr_ld", INO | MDRI));
    tbl.push_back(mk("ram_top_wr", RAMW));
    tbl.push_back(mk("mdr_zero", MDRI));
    tbl.push_back(mk("mdr_zero_rd", MDRO, 32'h0, 1'b1, 32'h0));
    tbl.push_back(mk("mdr_ram", MRD | MDRI));
    tbl.push_back(mk("ram_top_rd", MDRO, 32'h0, 1'b1, 32'hDEAD_BEEF));
    // CON with C2=01 then C2=11
    tbl.push_back(mk("c01_ir_in", INI, 32'h0008_0000));
    tbl.push_back(mk("c01_ir", INO | IRI));
    tbl.push_back(mk("c01_nz", INO | CONI, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1));
    tbl.push_back(mk("c01_z", CONI, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0));
    tbl.push_back(mk("c11_ir_in", INI, 32'h0018_0000));
    tbl.push_back(mk("c11_ir", INO | IRI));
    tbl.push_back(mk("c11_b_in", INI, 32'h8000_0000));
    tbl.push_back(mk("c11_neg", INO | CONI, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1));
    // BAout/Rout with Ra=0 and R0=9
    tbl.push_back(mk("r0_in", INI, 32'd9));
    tbl.push_back(mk("r0_ld", INO | GRA | RI));
    tbl.push_back(mk("baout_r0", GRA | BAO, 32'h0, 1'b1, 32'h0));
    tbl.push_back(mk("rout_r0", GRA | RO, 32'h0, 1'b1, 32'd9));
    tbl.push_back(mk("rout_nosel", RO, 32'h0, 1'b1, 32'h0));
    // Sign-extended constant and bus priority
    tbl.push_back(mk("rc_ir_in", INI, 32'h0004_0005));
    tbl.push_back(mk("rc_ir", INO | IRI));
    tbl.push_back(mk("rcout", RCO, 32'h0, 1'b1, 32'hFFFC_0005));
    tbl.push_back(mk("pc_mdr_prio", PCO | MDRO, 32'h0, 1'b1, 32'h0000_0001));

    foreach (tbl[i]) step(tbl[i]);

    v = mk("idle", 36'h0);
    step(v);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
